// File: rtl/cram_frame_loader.sv
// Configuration-memory frame loader: assembles bitstream words into frames,
// writes them out one per strobe, and optionally checks a trailing CRC-16-CCITT.
module cram_frame_loader #(
  parameter  int DATA_W     = 8,
  parameter  int FRAME_W    = 64,
  parameter  int NUM_FRAMES = 16,
  parameter  int CRC_EN     = 1,
  localparam int AW         = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               frame_we,
  output logic [AW-1:0]      frame_addr,
  output logic [FRAME_W-1:0] frame_data,
  output logic               busy,
  output logic               done,
  output logic               crc_err
);

  localparam int WPF  = FRAME_W / DATA_W;
  localparam int CRCW = 16 / DATA_W;
  localparam int MAXW = (WPF > CRCW) ? WPF : CRCW;
  localparam int WCW  = $clog2(MAXW + 1);
  // One extra bit lets the frame counter reach NUM_FRAMES without wrapping.
  localparam int FCW  = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_CRC,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [FCW-1:0]     frame_cnt_q, frame_cnt_d;
  logic [WCW-1:0]     word_cnt_q, word_cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [15:0]        crc_q, crc_d;
  logic [15:0]        rx_crc_q, rx_crc_d;
  logic [AW-1:0]      frame_addr_q, frame_addr_d;
  logic [FRAME_W-1:0] frame_data_q, frame_data_d;
  logic               crc_err_q, crc_err_d;
  logic               accept;

  // MSB-first CRC-16-CCITT over one input word.
  function automatic logic [15:0] crc_step(input logic [15:0] c,
                                           input logic [DATA_W-1:0] d);
    logic [15:0] r;
    r = c;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = (r << 1) ^ 16'h1021;
      else              r = r << 1;
    end
    return r;
  endfunction

  assign in_ready   = (state_q == S_LOAD) || (state_q == S_CRC);
  assign accept     = in_valid && in_ready;
  assign frame_we   = (state_q == S_WRITE);
  assign busy       = (state_q == S_LOAD) || (state_q == S_WRITE) || (state_q == S_CRC);
  assign done       = (state_q == S_DONE);
  assign crc_err    = crc_err_q;
  assign frame_addr = frame_addr_q;
  assign frame_data = frame_data_q;

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    word_cnt_d   = word_cnt_q;
    shift_d      = shift_q;
    crc_d        = crc_q;
    rx_crc_d     = rx_crc_q;
    frame_addr_d = frame_addr_q;
    frame_data_d = frame_data_q;
    crc_err_d    = crc_err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_LOAD;
          crc_err_d   = 1'b0;
          frame_cnt_d = '0;
          word_cnt_d  = '0;
          shift_d     = '0;
          rx_crc_d    = '0;
          crc_d       = 16'hFFFF;
        end
      end

      S_LOAD: begin
        if (accept) begin
          shift_d    = (shift_q << DATA_W) | FRAME_W'(in_data);
          crc_d      = crc_step(crc_q, in_data);
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == WCW'(WPF - 1)) begin
            state_d      = S_WRITE;
            frame_data_d = shift_d;
            frame_addr_d = frame_cnt_q[AW-1:0];
          end
        end
      end

      S_WRITE: begin
        word_cnt_d  = '0;
        frame_cnt_d = frame_cnt_q + 1'b1;
        if (frame_cnt_q == FCW'(NUM_FRAMES - 1)) begin
          state_d = (CRC_EN != 0) ? S_CRC : S_DONE;
        end else begin
          state_d = S_LOAD;
        end
      end

      S_CRC: begin
        if (accept) begin
          rx_crc_d   = (rx_crc_q << DATA_W) | 16'(in_data);
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == WCW'(CRCW - 1)) begin
            crc_err_d = (rx_crc_d != crc_q);
            state_d   = S_DONE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      frame_cnt_q  <= '0;
      word_cnt_q   <= '0;
      shift_q      <= '0;
      crc_q        <= '0;
      rx_crc_q     <= '0;
      frame_addr_q <= '0;
      frame_data_q <= '0;
      crc_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      word_cnt_q   <= word_cnt_d;
      shift_q      <= shift_d;
      crc_q        <= crc_d;
      rx_crc_q     <= rx_crc_d;
      frame_addr_q <= frame_addr_d;
      frame_data_q <= frame_data_d;
      crc_err_q    <= crc_err_d;
    end
  end

endmodule

// File: tb/tb_cram_frame_loader.sv
// Directed bench for cram_frame_loader: two-frame loads with CRC check,
// stalls, start handling, async reset, and a CRC-less instance.
module tb_cram_frame_loader;

  localparam logic [15:0] GOOD_CRC = 16'h30EC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        in_ready, frame_we, busy, done, crc_err;
  logic [0:0]  frame_addr;
  logic [15:0] frame_data;
  logic        in_ready2, frame_we2, busy2, done2, crc_err2;
  logic [0:0]  frame_addr2;
  logic [15:0] frame_data2;

  int checks = 0;
  int fails = 0;
  bit tgt = 1'b0;

  int          negCnt = 0;
  int          lastAcc = 0;
  int          weAddr[$];
  logic [15:0] weData[$];
  int          weLat[$];
  int          readyDuringWrite = 0;
  int          we2Addr[$];
  logic [15:0] we2Data[$];
  logic [7:0]  stream[$];

  cram_frame_loader #(.DATA_W(8), .FRAME_W(16), .NUM_FRAMES(2), .CRC_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .frame_we(frame_we), .frame_addr(frame_addr),
    .frame_data(frame_data), .busy(busy), .done(done), .crc_err(crc_err)
  );

  cram_frame_loader #(.DATA_W(8), .FRAME_W(16), .NUM_FRAMES(2), .CRC_EN(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .frame_we(frame_we2), .frame_addr(frame_addr2),
    .frame_data(frame_data2), .busy(busy2), .done(done2), .crc_err(crc_err2)
  );

  always #5 clk = ~clk;

  // Record every write strobe, with its distance from the last accepted word.
  always @(negedge clk) begin
    if (frame_we) begin
      weAddr.push_back(int'(frame_addr));
      weData.push_back(frame_data);
      weLat.push_back(negCnt - lastAcc);
      if (in_ready) readyDuringWrite++;
    end
    if (in_valid && in_ready) lastAcc = negCnt;
    if (frame_we2) begin
      we2Addr.push_back(int'(frame_addr2));
      we2Data.push_back(frame_data2);
    end
    negCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearMon();
    weAddr.delete();
    weData.delete();
    weLat.delete();
    we2Addr.delete();
    we2Data.delete();
    readyDuringWrite = 0;
  endtask

  task automatic pulseStart();
    if (tgt) start2 = 1'b1;
    else     start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] word, input bit gap);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = word;
    while (!(tgt ? in_ready2 : in_ready) && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!(tgt ? in_ready2 : in_ready)) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic sendStream(input bit gap);
    foreach (stream[i]) applyStimulus(stream[i], gap);
    in_valid = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int w;
    w = 0;
    while (!(tgt ? done2 : done) && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    checkOutput(tag, 32'(tgt ? done2 : done), 32'd1);
  endtask

  task automatic checkWrites(input string tag, input logic [15:0] d0, input logic [15:0] d1);
    int n;
    logic [15:0] expData[2];
    expData[0] = d0;
    expData[1] = d1;
    n = tgt ? we2Addr.size() : weAddr.size();
    checkOutput($sformatf("%s_count", tag), 32'(n), 32'd2);
    for (int i = 0; i < 2; i++) begin
      if (i < n) begin
        if (tgt) begin
          checkOutput($sformatf("%s_addr%0d", tag, i), 32'(we2Addr[i]), 32'(i));
          checkOutput($sformatf("%s_data%0d", tag, i), 32'(we2Data[i]), 32'(expData[i]));
        end else begin
          checkOutput($sformatf("%s_addr%0d", tag, i), 32'(weAddr[i]), 32'(i));
          checkOutput($sformatf("%s_data%0d", tag, i), 32'(weData[i]), 32'(expData[i]));
          checkOutput($sformatf("%s_lat%0d", tag, i), 32'(weLat[i]), 32'd1);
        end
      end
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput($sformatf("%s_in_ready", tag), 32'(in_ready), 32'd0);
    checkOutput($sformatf("%s_frame_we", tag), 32'(frame_we), 32'd0);
    checkOutput($sformatf("%s_frame_addr", tag), 32'(frame_addr), 32'd0);
    checkOutput($sformatf("%s_frame_data", tag), 32'(frame_data), 32'd0);
    checkOutput($sformatf("%s_busy", tag), 32'(busy), 32'd0);
    checkOutput($sformatf("%s_done", tag), 32'(done), 32'd0);
    checkOutput($sformatf("%s_crc_err", tag), 32'(crc_err), 32'd0);
  endtask

  initial begin
    #3;
    checkResetOutputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_ready", 32'(in_ready), 32'd0);

    $display("[TB] good CRC load, in_valid held high");
    stream = '{8'h12, 8'h34, 8'h56, 8'h78, GOOD_CRC[15:8], GOOD_CRC[7:0]};
    clearMon();
    pulseStart();
    checkOutput("a_busy", 32'(busy), 32'd1);
    sendStream(1'b0);
    waitDone("a_done");
    checkWrites("a", 16'h1234, 16'h5678);
    checkOutput("a_crc_err", 32'(crc_err), 32'd0);
    checkOutput("a_busy_done", 32'(busy), 32'd0);
    checkOutput("a_ready_done", 32'(in_ready), 32'd0);
    checkOutput("a_hold_data", 32'(frame_data), 32'h5678);
    checkOutput("a_hold_addr", 32'(frame_addr), 32'd1);

    $display("[TB] corrupted CRC load");
    stream = '{8'h12, 8'h34, 8'h56, 8'h78, GOOD_CRC[15:8], GOOD_CRC[7:0] ^ 8'h01};
    clearMon();
    pulseStart();
    sendStream(1'b0);
    waitDone("b_done");
    checkWrites("b", 16'h1234, 16'h5678);
    checkOutput("b_crc_err", 32'(crc_err), 32'd1);

    $display("[TB] restart from DONE, stalled load with stray start");
    clearMon();
    pulseStart();
    checkOutput("c_done_clr", 32'(done), 32'd0);
    checkOutput("c_crc_err_clr", 32'(crc_err), 32'd0);
    checkOutput("c_busy", 32'(busy), 32'd1);
    applyStimulus(8'h12, 1'b1);
    pulseStart();
    checkOutput("c_busy_after_start", 32'(busy), 32'd1);
    applyStimulus(8'h34, 1'b1);
    applyStimulus(8'h56, 1'b1);
    applyStimulus(8'h78, 1'b1);
    applyStimulus(GOOD_CRC[15:8], 1'b1);
    applyStimulus(GOOD_CRC[7:0], 1'b1);
    waitDone("c_done");
    checkWrites("c", 16'h1234, 16'h5678);
    checkOutput("c_crc_err", 32'(crc_err), 32'd0);
    checkOutput("c_ready_in_write", 32'(readyDuringWrite), 32'd0);

    $display("[TB] reset in the middle of a load");
    clearMon();
    pulseStart();
    applyStimulus(8'h12, 1'b0);
    applyStimulus(8'h34, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h56;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("mid");
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("mid_writes", 32'(weAddr.size()), 32'd1);
    checkOutput("mid_wait_busy", 32'(busy), 32'd0);
    stream = '{8'h12, 8'h34, 8'h56, 8'h78, GOOD_CRC[15:8], GOOD_CRC[7:0]};
    clearMon();
    pulseStart();
    sendStream(1'b0);
    waitDone("r_done");
    checkWrites("r", 16'h1234, 16'h5678);
    checkOutput("r_crc_err", 32'(crc_err), 32'd0);

    $display("[TB] CRC-less instance");
    tgt = 1'b1;
    stream = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    clearMon();
    pulseStart();
    sendStream(1'b0);
    waitDone("n_done");
    checkWrites("n", 16'hAABB, 16'hCCDD);
    checkOutput("n_crc_err", 32'(crc_err2), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("n_ready_done", 32'(in_ready2), 32'd0);
    checkOutput("n_busy_done", 32'(busy2), 32'd0);
    checkOutput("n_no_extra_we", 32'(we2Addr.size()), 32'd2);
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/cram_frame_loader.md
CRAM_FRAME_LOADER -- requirements
Module: cram_frame_loader

Interface
REQ-001 Parameter DATA_W, default 8, input word width in bits; SHALL divide FRAME_W and 16.
REQ-002 Parameter FRAME_W, default 64, bits per configuration frame.
REQ-003 Parameter NUM_FRAMES, default 16, frames per load; AW = max(1, clog2(NUM_FRAMES)).
REQ-004 Parameter CRC_EN, default 1; 1 = trailing CRC-16 checked, 0 = no CRC phase.
REQ-005 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 Port start, input, 1, single-cycle request to begin a load.
REQ-008 Port in_valid, input, 1, in_data holds a valid word.
REQ-009 Port in_data, input, DATA_W, bitstream word; MSB is first on the wire.
REQ-010 Port in_ready, output, 1, loader accepts a word when in_valid && in_ready.
REQ-011 Port frame_we, output, 1, one-cycle frame write strobe.
REQ-012 Port frame_addr, output, AW, frame index being written.
REQ-013 Port frame_data, output, FRAME_W, assembled frame; first word in the MSBs.
REQ-014 Port busy, output, 1, high in every state except IDLE and DONE.
REQ-015 Port done, output, 1, load finished; held until next start.
REQ-016 Port crc_err, output, 1, CRC mismatch on the last load; held until next start.

Function
REQ-017 States SHALL be IDLE, LOAD, WRITE, CRC, DONE.
REQ-018 IDLE or DONE with start=1 SHALL go to LOAD, clear done, crc_err, frame counter, word counter and shift register, and set CRC to 0xFFFF.
REQ-019 start SHALL be ignored in LOAD, WRITE and CRC.
REQ-020 in_ready SHALL be 1 only in LOAD and CRC.
REQ-021 In LOAD, each accepted word SHALL shift into the frame register from the LSB side; the word counter SHALL increment.
REQ-022 The accept of word FRAME_W/DATA_W of a frame SHALL move the FSM to WRITE on the next edge.
REQ-023 In WRITE, frame_we=1 for exactly one cycle with frame_addr = frame counter and frame_data = the completed frame.
REQ-024 WRITE SHALL increment the frame counter and clear the word counter. Next state: LOAD if frames remain; otherwise CRC if CRC_EN=1, else DONE.
REQ-025 Latency from accepting a frame's last word to frame_we SHALL be 1 cycle. Steady-state throughput SHALL be FRAME_W/DATA_W words per FRAME_W/DATA_W+1 cycles.
REQ-026 CRC SHALL be CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR), updated over every frame word accepted in LOAD, DATA_W bits per cycle.
REQ-027 In CRC, 16/DATA_W words SHALL be accepted and assembled MSB-first into the received CRC; they SHALL NOT update the running CRC.
REQ-028 After the last CRC word: crc_err = (received != running CRC); next state DONE.
REQ-029 In DONE, done=1, busy=0, in_ready=0, and frame_we SHALL NOT assert.
REQ-030 in_valid=0 in LOAD or CRC SHALL stall without changing any state.
REQ-031 frame_addr SHALL never exceed NUM_FRAMES-1. The frame counter SHALL NOT wrap within a load.
REQ-032 frame_data and frame_addr SHALL hold their values outside WRITE.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE and clear all counters, the shift register and the CRC. Outputs SHALL be: in_ready=0, frame_we=0, frame_addr=0, frame_data=0, busy=0, done=0, crc_err=0.
REQ-034 Reset asserted mid-load SHALL abandon the load with no further frame_we. Release SHALL be honoured on the first clk edge after rst_n rises, and the block SHALL wait for start.

Verification (DATA_W=8, FRAME_W=16, NUM_FRAMES=2, CRC_EN=1 unless noted)
REQ-035 Stimulus: start, then words 0x12,0x34,0x56,0x78, then the correct CRC as 2 bytes, in_valid always 1. Response: frame_we with addr 0/data 0x1234, then addr 1/data 0x5678, each 1 cycle after the 2nd byte of its frame; done=1, crc_err=0.
REQ-036 Stimulus: same stream with the last CRC byte XOR 0x01. Response: both frames written, done=1, crc_err=1.
REQ-037 Stimulus: in_valid toggling 1/0 every cycle through the load. Response: identical frame_we addr/data sequence, in_ready=0 during WRITE, no word lost or duplicated.
REQ-038 Stimulus: rst_n=0 one cycle after the first frame_we. Response: outputs reach reset values without waiting for clk; no addr-1 write; after release and a new start, the full load completes.
REQ-039 Stimulus: start pulsed during LOAD. Response: ignored, counters unchanged. Stimulus: start in DONE. Response: done and crc_err cleared, new load begins at addr 0.
REQ-040 Stimulus: CRC_EN=0, words 0xAA,0xBB,0xCC,0xDD. Response: writes 0xAABB at addr 0 and 0xCCDD at addr 1, then DONE with no CRC words accepted and crc_err=0.
